// File: rtl/simple_decomp_if.sv
// Valid/ready bus for simple_decomp: operand input side, result output side and delivered-result count.
interface simple_decomp_if #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CNT_WIDTH = 16
);
  logic [WIDTH-1:0]     d_in;
  logic [WIDTH-1:0]     b_in;
  logic [WIDTH-1:0]     c_in;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a_out;
  logic                 underflow_out;
  logic                 out_valid;
  logic                 out_ready;
  logic [CNT_WIDTH-1:0] count_out;

  // Producer/consumer side.
  modport master (
    output d_in, b_in, c_in, in_valid, out_ready,
    input  in_ready, a_out, underflow_out, out_valid, count_out
  );

  // Pipeline side.
  modport slave (
    input  d_in, b_in, c_in, in_valid, out_ready,
    output in_ready, a_out, underflow_out, out_valid, count_out
  );
endinterface

// File: rtl/simple_decomp.sv
// Two-stage pipelined subtractor recovering a = d - c - b from a registered add chain,
// with per-result borrow flag and a wrap-around delivered-result counter.
module simple_decomp #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  simple_decomp_if.slave bus
);

  localparam int unsigned XW = WIDTH + 1;

  logic                 s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]     s1_diff_q,  s1_diff_d;
  logic                 s1_borrow_q, s1_borrow_d;
  logic [WIDTH-1:0]     s1_b_q,     s1_b_d;

  logic                 s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]     s2_diff_q,  s2_diff_d;
  logic                 s2_uf_q,    s2_uf_d;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                 s1_adv_c;
  logic                 s2_adv_c;
  logic                 out_xfer_c;
  logic [XW-1:0]        sub1_c;
  logic [XW-1:0]        sub2_c;

  // Advance/hold decisions and next-state values; the extra MSB of each difference is its borrow.
  always_comb begin
    s2_adv_c    = !s2_valid_q || bus.out_ready;
    s1_adv_c    = !s1_valid_q || s2_adv_c;
    out_xfer_c  = s2_valid_q && bus.out_ready;
    sub1_c      = XW'({1'b0, bus.d_in}) - XW'({1'b0, bus.c_in});
    sub2_c      = XW'({1'b0, s1_diff_q}) - XW'({1'b0, s1_b_q});

    s1_valid_d  = s1_valid_q;
    s1_diff_d   = s1_diff_q;
    s1_borrow_d = s1_borrow_q;
    s1_b_d      = s1_b_q;
    s2_valid_d  = s2_valid_q;
    s2_diff_d   = s2_diff_q;
    s2_uf_d     = s2_uf_q;
    cnt_d       = cnt_q;

    if (s1_adv_c) begin
      s1_valid_d  = bus.in_valid;
      s1_diff_d   = sub1_c[WIDTH-1:0];
      s1_borrow_d = sub1_c[WIDTH];
      s1_b_d      = bus.b_in;
    end

    if (s2_adv_c) begin
      s2_valid_d = s1_valid_q;
      s2_diff_d  = sub2_c[WIDTH-1:0];
      s2_uf_d    = s1_borrow_q | sub2_c[WIDTH];
    end

    if (out_xfer_c) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_diff_q   <= '0;
      s1_borrow_q <= 1'b0;
      s1_b_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_diff_q   <= '0;
      s2_uf_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_diff_q   <= s1_diff_d;
      s1_borrow_q <= s1_borrow_d;
      s1_b_q      <= s1_b_d;
      s2_valid_q  <= s2_valid_d;
      s2_diff_q   <= s2_diff_d;
      s2_uf_q     <= s2_uf_d;
      cnt_q       <= cnt_d;
    end
  end

  // in_ready is combinational from out_ready so a full pipe still streams at one per cycle.
  assign bus.in_ready      = s1_adv_c;
  assign bus.a_out         = s2_diff_q;
  assign bus.underflow_out = s2_uf_q;
  assign bus.out_valid     = s2_valid_q;
  assign bus.count_out     = cnt_q;

endmodule

// File: tb/tb_simple_decomp.sv
// Scoreboard bench for simple_decomp: expected results queued on input transfer, checked on output transfer.
module tb_simple_decomp;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  simple_decomp_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();
  simple_decomp #(.WIDTH(W), .CNT_WIDTH(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [W-1:0] a;
    logic         uf;
  } exp_t;

  exp_t         sb[$];
  int           n_total = 0;
  int           n_pass  = 0;
  int           n_out   = 0;
  logic [CW-1:0] m_cnt  = '0;

  // Reference: wrapped difference, and borrow iff d < c + b in full precision.
  function automatic exp_t model(input logic [W-1:0] d, input logic [W-1:0] b, input logic [W-1:0] c);
    exp_t       e;
    logic [W:0] cb;
    e.a  = W'(d - c - b);
    cb   = {1'b0, c} + {1'b0, b};
    e.uf = ({1'b0, d} < cb);
    return e;
  endfunction

  // Monitor on the falling edge: inputs and outputs are stable for the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      m_cnt = '0;
    end else begin
      n_total++;
      if (bus.count_out !== m_cnt) $display("FAIL count_track: got %0d expected %0d", bus.count_out, m_cnt);
      else n_pass++;
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_output: a_out=%h with empty scoreboard", bus.a_out);
        end else begin
          e = sb.pop_front();
          if (bus.a_out !== e.a || bus.underflow_out !== e.uf)
            $display("FAIL result: got a=%h uf=%b expected a=%h uf=%b", bus.a_out, bus.underflow_out, e.a, e.uf);
          else n_pass++;
        end
        m_cnt = m_cnt + CW'(1);
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.d_in, bus.b_in, bus.c_in));
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [W-1:0] b, input logic [W-1:0] c);
    bit ok = 1'b0;
    bus.d_in = d; bus.b_in = b; bus.c_in = c; bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk); #1;
      if (ok) break;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      n_total++;
      $display("FAIL send_timeout: d=%h never accepted, expected acceptance within 50 cycles", d);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.out_valid) break;
    end
    n_total++;
    if (sb.size() != 0) $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.d_in = 16'd9; bus.b_in = '0; bus.c_in = '0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #2;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); else n_pass++;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.a_out !== 16'h0) $display("FAIL rst_a_out: got %h expected 0000", bus.a_out); else n_pass++;
    n_total++; if (bus.underflow_out !== 1'b0) $display("FAIL rst_uf: got %b expected 0", bus.underflow_out); else n_pass++;
    n_total++; if (bus.count_out !== 4'd0) $display("FAIL rst_count: got %0d expected 0", bus.count_out); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_no_xfer: got out_valid %b expected 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    send(16'd100, 16'd20, 16'd30);
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL basic_latency_early: got out_valid %b expected 0", bus.out_valid); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus.out_valid !== 1'b1) $display("FAIL basic_valid: got %b expected 1", bus.out_valid); else n_pass++;
    n_total++; if (bus.a_out !== 16'd50) $display("FAIL basic_a: got %0d expected 50", bus.a_out); else n_pass++;
    n_total++; if (bus.underflow_out !== 1'b0) $display("FAIL basic_uf: got %b expected 0", bus.underflow_out); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL basic_one_cycle: got out_valid %b expected 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.count_out !== 4'd1) $display("FAIL basic_count: got %0d expected 1", bus.count_out); else n_pass++;
  endtask

  task automatic test_borrow();
    bus.out_ready = 1'b1;
    send(16'd5, 16'd0, 16'd10);
    @(posedge clk); #1;
    n_total++; if (bus.a_out !== 16'hFFFB || bus.underflow_out !== 1'b1)
      $display("FAIL borrow1: got a=%h uf=%b expected a=fffb uf=1", bus.a_out, bus.underflow_out); else n_pass++;
    @(posedge clk); #1;
    send(16'd10, 16'd6, 16'd5);
    @(posedge clk); #1;
    n_total++; if (bus.a_out !== 16'hFFFF || bus.underflow_out !== 1'b1)
      $display("FAIL borrow2: got a=%h uf=%b expected a=ffff uf=1", bus.a_out, bus.underflow_out); else n_pass++;
    drain();
  endtask

  task automatic test_backpressure();
    int out0 = n_out;
    bus.out_ready = 1'b1;
    fork
      begin
        for (int d = 1; d <= 6; d++) send(W'(d), 16'd0, 16'd0);
      end
      begin
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b expected 0", bus.in_ready); else n_pass++;
        n_total++; if (bus.a_out !== 16'd1 || bus.out_valid !== 1'b1)
          $display("FAIL bp_head: got a=%0d v=%b expected a=1 v=1", bus.a_out, bus.out_valid); else n_pass++;
        repeat (2) begin
          @(posedge clk); #1;
          @(negedge clk);
          n_total++; if (bus.a_out !== 16'd1 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
            $display("FAIL bp_hold: got a=%0d v=%b rdy=%b expected a=1 v=1 rdy=0", bus.a_out, bus.out_valid, bus.in_ready);
          else n_pass++;
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    n_total++; if (n_out - out0 != 6) $display("FAIL bp_out_count: got %0d outputs expected 6", n_out - out0); else n_pass++;
  endtask

  task automatic test_stream();
    int out0 = n_out;
    bit gap  = 1'b0;
    bit seen = 1'b0;
    bus.out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 100; i++)
          send(W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)));
      end
      begin
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge clk);
          if (bus.out_valid) seen = 1'b1;
        end
        for (int i = 0; i < 99; i++) begin
          @(negedge clk);
          if (!bus.out_valid) gap = 1'b1;
        end
      end
    join
    n_total++; if (!seen || gap) $display("FAIL stream_continuous: got seen=%b gap=%b expected seen=1 gap=0", seen, gap); else n_pass++;
    drain();
    n_total++; if (n_out - out0 != 100) $display("FAIL stream_out_count: got %0d expected 100", n_out - out0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    send(16'd11, 16'd1, 16'd1);
    send(16'd12, 16'd1, 16'd1);
    #3 rst = 1'b1;
    #2;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rmid_valid: got %b expected 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.a_out !== 16'h0) $display("FAIL rmid_a: got %h expected 0000", bus.a_out); else n_pass++;
    n_total++; if (bus.count_out !== 4'd0) $display("FAIL rmid_count: got %0d expected 0", bus.count_out); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL rmid_in_ready: got %b expected 1", bus.in_ready); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send(16'd7, 16'd1, 16'd2);
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rmid_latency_early: got %b expected 0", bus.out_valid); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus.out_valid !== 1'b1 || bus.a_out !== 16'd4)
      $display("FAIL rmid_result: got v=%b a=%0d expected v=1 a=4", bus.out_valid, bus.a_out); else n_pass++;
    drain();
  endtask

  task automatic test_count_wrap();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      send(W'(i), 16'd0, 16'd0);
      @(posedge clk);
      @(posedge clk); #1;
      if (i >= 15) begin
        n_total++;
        if (bus.count_out !== CW'(i % 16)) $display("FAIL count_wrap_%0d: got %0d expected %0d", i, bus.count_out, i % 16);
        else n_pass++;
      end
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.d_in = '0; bus.b_in = '0; bus.c_in = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_borrow();
    test_backpressure();
    test_stream();
    test_reset_mid();
    test_count_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
